// File: rtl/mem_bus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_ctrl_pkg
// Description : Shared types and constants for the memory bus controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_ctrl_pkg;

    // Bus controller states
    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_RD   = 2'd1,
        BUS_WR   = 2'd2,
        BUS_DONE = 2'd3
    } bus_state_t;

    // Default number of cycles to wait for the memory acknowledge
    localparam int DEFAULT_BUS_TIMEOUT = 255;

    // Value returned as read data when a read times out
    localparam logic [15:0] RD_ERR_FILL = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/bus_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : bus_wait_counter
// Description : Wait-state counter with synchronous load to zero, increment,
//               saturation at all-ones and a terminal-count flag at LIMIT-1.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_wait_counter #(
    parameter int W     = 8,
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_inc,
    output logic o_tc
);

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] TC_VAL  = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins over increment; increment stops at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tc = (cnt_q == TC_VAL);

endmodule
`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_ctrl
// Description : Latches datapath memory accesses, drives active-low memory
//               strobes until mem_ready, returns read data, stalls the control
//               path while busy and flags accesses that are never acknowledged.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = DEFAULT_BUS_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset_L,
    input  logic              re_L,
    input  logic              we_L,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              bus_err,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd_L,
    output logic              mem_wr_L,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    bus_state_t        state_q,     state_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;
    logic              bus_err_q,   bus_err_d;
    logic              mem_rd_L_q,  mem_rd_L_d;
    logic              mem_wr_L_q,  mem_wr_L_d;
    logic              armed_q,     armed_d;

    logic              cnt_load;
    logic              cnt_inc;
    logic              cnt_tc;
    logic              timeout;
    logic              req_valid;

    // Wait-state counter, loaded on access start, bumped per unacknowledged cycle
    bus_wait_counter #(
        .W     (CNT_W),
        .LIMIT (TIMEOUT)
    ) u_wait_cnt (
        .clk    (clock),
        .rst_n  (reset_L),
        .i_load (cnt_load),
        .i_inc  (cnt_inc),
        .o_tc   (cnt_tc)
    );

    // A request only counts once the previous one has been withdrawn
    assign req_valid = armed_q && (!re_L || !we_L);

    // Next-state, latching, timeout and strobe decode
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        cnt_load    = 1'b0;
        cnt_inc     = 1'b0;
        timeout     = 1'b0;
        armed_d     = armed_q | (re_L & we_L);

        case (state_q)
            BUS_IDLE: begin
                // Read has priority when both requests are asserted
                if (armed_q && !re_L) begin
                    mem_addr_d = addr;
                    cnt_load   = 1'b1;
                    state_d    = BUS_RD;
                end else if (armed_q && !we_L) begin
                    mem_addr_d  = addr;
                    mem_wdata_d = wdata;
                    cnt_load    = 1'b1;
                    state_d     = BUS_WR;
                end
            end
            BUS_RD: begin
                if (mem_ready) begin
                    rdata_d = mem_rdata;
                    state_d = BUS_DONE;
                end else if (cnt_tc) begin
                    timeout = 1'b1;
                    rdata_d = DATA_W'(RD_ERR_FILL);
                    state_d = BUS_DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            BUS_WR: begin
                if (mem_ready) begin
                    state_d = BUS_DONE;
                end else if (cnt_tc) begin
                    timeout = 1'b1;
                    state_d = BUS_DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            BUS_DONE: begin
                state_d = BUS_IDLE;
            end
            default: begin
                state_d = BUS_IDLE;
            end
        endcase

        // Entering DONE disarms until the control word goes idle again
        if (state_d == BUS_DONE) begin
            armed_d = 1'b0;
        end

        // A timeout in the same cycle as a clear leaves the flag set
        bus_err_d  = timeout | (bus_err_q & ~err_clr);

        // Strobes are registered from the next state so they track RD/WR exactly
        mem_rd_L_d = (state_d != BUS_RD);
        mem_wr_L_d = (state_d != BUS_WR);
    end

    // Controller state and registered outputs; reset aborts any access
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= BUS_IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            bus_err_q   <= 1'b0;
            mem_rd_L_q  <= 1'b1;
            mem_wr_L_q  <= 1'b1;
            armed_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            bus_err_q   <= bus_err_d;
            mem_rd_L_q  <= mem_rd_L_d;
            mem_wr_L_q  <= mem_wr_L_d;
            armed_q     <= armed_d;
        end
    end

    // Stall while an access is in flight or about to start
    always_comb begin
        stall = 1'b0;
        if ((state_q == BUS_RD) || (state_q == BUS_WR)) begin
            stall = 1'b1;
        end else if ((state_q == BUS_IDLE) && req_valid) begin
            stall = 1'b1;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;
    assign bus_err   = bus_err_q;
    assign mem_rd_L  = mem_rd_L_q;
    assign mem_wr_L  = mem_wr_L_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_ctrl
// Description : Self-checking bench for mem_bus_ctrl with a transaction-level
//               reference model (strobe length, returned data, error flag).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_bus_ctrl;

    localparam int TMO = 8;

    logic        clock;
    logic        reset_L;
    logic        re_L;
    logic        we_L;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        stall;
    logic        bus_err;
    logic        err_clr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd_L;
    logic        mem_wr_L;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    int          cmp_cnt;
    int          err_cnt;
    logic [15:0] exp_rdata;
    logic        exp_err;

    mem_bus_ctrl #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .TIMEOUT (TMO)
    ) dut (
        .clock     (clock),
        .reset_L   (reset_L),
        .re_L      (re_L),
        .we_L      (we_L),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .bus_err   (bus_err),
        .err_clr   (err_clr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd_L  (mem_rd_L),
        .mem_wr_L  (mem_wr_L),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp)
        else begin
            err_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Quiet bus: no request, memory noise must be ignored
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            re_L      = 1'b1;
            we_L      = 1'b1;
            mem_ready = 1'($urandom);
            mem_rdata = 16'($urandom);
            #1;
            chk("idle_stall", stall, 1'b0);
            chk("idle_rd_L", mem_rd_L, 1'b1);
            chk("idle_wr_L", mem_wr_L, 1'b1);
            chk("idle_rdata", rdata, exp_rdata);
            chk("idle_bus_err", bus_err, exp_err);
        end
    endtask

    // One access. Expected strobe length: waits+1 if acknowledged, TMO if not.
    task automatic access(input bit rd, input bit both, input logic [15:0] a,
                          input logic [15:0] d, input int waits, input logic [15:0] mval,
                          input bit clr_end, input int hold);
        bit timed_out;
        bit do_rd;
        int n;
        do_rd     = rd || both;
        timed_out = (waits >= TMO);
        n         = timed_out ? TMO : waits + 1;

        @(posedge clock); #1;
        addr      = a;
        wdata     = d;
        re_L      = !do_rd;
        we_L      = !(both || !rd);
        mem_ready = 1'($urandom);
        mem_rdata = 16'($urandom);
        #1;
        chk("req_stall", stall, 1'b1);
        chk("req_rd_L", mem_rd_L, 1'b1);
        chk("req_wr_L", mem_wr_L, 1'b1);

        for (int k = 1; k <= n; k++) begin
            @(posedge clock); #1;
            addr      = 16'($urandom);
            wdata     = 16'($urandom);
            mem_ready = (k == waits + 1);
            mem_rdata = mem_ready ? mval : 16'($urandom);
            err_clr   = clr_end && (k == n);
            #1;
            chk("busy_rd_L", mem_rd_L, !do_rd);
            chk("busy_wr_L", mem_wr_L, do_rd);
            chk("busy_addr", mem_addr, a);
            if (!do_rd) chk("busy_wdata", mem_wdata, d);
            chk("busy_stall", stall, 1'b1);
        end

        if (do_rd) exp_rdata = timed_out ? 16'hFFFF : mval;
        if (timed_out) exp_err = 1'b1;
        else if (clr_end) exp_err = 1'b0;

        @(posedge clock); #1;
        err_clr   = 1'b0;
        mem_ready = 1'($urandom);
        if (hold == 0) begin
            re_L = 1'b1;
            we_L = 1'b1;
        end
        #1;
        chk("done_stall", stall, 1'b0);
        chk("done_rd_L", mem_rd_L, 1'b1);
        chk("done_wr_L", mem_wr_L, 1'b1);
        chk("done_rdata", rdata, exp_rdata);
        chk("done_bus_err", bus_err, exp_err);

        for (int h = 0; h < hold; h++) begin
            @(posedge clock); #1;
            #1;
            chk("hold_stall", stall, 1'b0);
            chk("hold_rd_L", mem_rd_L, 1'b1);
            chk("hold_wr_L", mem_wr_L, 1'b1);
        end
        if (hold > 0) begin
            @(posedge clock); #1;
            re_L = 1'b1;
            we_L = 1'b1;
            #1;
            chk("release_stall", stall, 1'b0);
        end
    endtask

    task automatic clear_err();
        @(posedge clock); #1;
        err_clr = 1'b1;
        @(posedge clock); #1;
        err_clr = 1'b0;
        exp_err = 1'b0;
        #1;
        chk("clr_bus_err", bus_err, 1'b0);
    endtask

    initial begin
        cmp_cnt   = 0;
        err_cnt   = 0;
        exp_rdata = 16'h0000;
        exp_err   = 1'b0;
        reset_L   = 1'b0;
        re_L      = 1'b1;
        we_L      = 1'b1;
        addr      = 16'h0;
        wdata     = 16'h0;
        err_clr   = 1'b0;
        mem_rdata = 16'h0;
        mem_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        #2;
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_mem_wdata", mem_wdata, 16'h0);
        chk("rst_rdata", rdata, 16'h0);
        chk("rst_bus_err", bus_err, 1'b0);
        chk("rst_rd_L", mem_rd_L, 1'b1);
        chk("rst_wr_L", mem_wr_L, 1'b1);
        reset_L = 1'b1;

        idle_cycles(20);

        // Zero-wait read
        access(1'b1, 1'b0, 16'h0040, 16'h0000, 0, 16'hBEEF, 1'b0, 0);
        idle_cycles(2);

        // Write with three wait states
        access(1'b0, 1'b0, 16'h1234, 16'hA5A5, 3, 16'h0000, 1'b0, 0);
        idle_cycles(2);

        // Read never acknowledged, then clear the error
        access(1'b1, 1'b0, 16'h0BAD, 16'h0000, 100, 16'h0000, 1'b0, 0);
        clear_err();
        idle_cycles(2);

        // Timeout coincident with a clear: the set wins
        access(1'b0, 1'b0, 16'h7777, 16'h5555, 20, 16'h0000, 1'b1, 0);
        clear_err();

        // Read and write together: read happens, then request held across DONE
        access(1'b1, 1'b1, 16'h2222, 16'h3333, 1, 16'hC0DE, 1'b0, 3);
        access(1'b1, 1'b0, 16'h2224, 16'h0000, 2, 16'h1357, 1'b0, 0);

        // Wait exactly one short of timeout
        access(1'b1, 1'b0, 16'h0099, 16'h0000, TMO - 1, 16'h2468, 1'b0, 0);

        // Reset pulsed during the second write wait state
        @(posedge clock); #1;
        addr  = 16'h4321;
        wdata = 16'h9876;
        we_L  = 1'b0;
        re_L  = 1'b1;
        repeat (2) begin
            @(posedge clock); #1;
            mem_ready = 1'b0;
        end
        #2;
        chk("pre_rst_wr_L", mem_wr_L, 1'b0);
        reset_L = 1'b0;
        we_L    = 1'b1;
        #1;
        exp_rdata = 16'h0000;
        exp_err   = 1'b0;
        chk("mid_rst_wr_L", mem_wr_L, 1'b1);
        chk("mid_rst_wdata", mem_wdata, 16'h0);
        chk("mid_rst_addr", mem_addr, 16'h0);
        chk("mid_rst_stall", stall, 1'b0);
        chk("mid_rst_rdata", rdata, 16'h0);
        @(posedge clock); #1;
        reset_L = 1'b1;
        idle_cycles(3);
        access(1'b0, 1'b0, 16'h0101, 16'hFACE, 0, 16'h0000, 1'b0, 0);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            bit rd_r;
            bit both_r;
            rd_r   = 1'($urandom);
            both_r = ($urandom_range(0, 7) == 0);
            access(rd_r, both_r, 16'($urandom), 16'($urandom), int'($urandom_range(0, 10)),
                   16'($urandom), 1'($urandom), int'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) clear_err();
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
